// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the SPI arbiter slice: transaction state encoding,
// the default SPI word width, the default chip-select active level and a
// helper that sizes counters from their largest value.
package spi_pkg;

    localparam int   SPI_DATA_W    = 16;
    localparam logic CS_ACTIVE_LVL = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if
// Handshake link between the arbiter and the shared 16-bit SPI master.
//   start    : arbiter -> master start_transfer
//   tx_data  : arbiter -> master data_to_tx
//   rx_data  : master -> arbiter data_rx
//   busy     : master -> arbiter transfer_busy
//   done     : master -> arbiter transfer_done (level, one bit-clock long)
//   cs       : master -> arbiter chip-select to be routed to the owner
// Modport master is used by the arbiter, slave by the SPI master side.
interface spi_arbiter_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) ();

    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
    logic              cs;

    modport master (
        output start,
        output tx_data,
        input  rx_data,
        input  busy,
        input  done,
        input  cs
    );

    modport slave (
        input  start,
        input  tx_data,
        output rx_data,
        output busy,
        output done,
        output cs
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick. Searches requesters starting just after
// the pointer and wrapping at N_REQ-1 -> 0; the first active request wins.
//   req   : per-requester request levels
//   ptr   : index of the most recently served requester
//   gnt   : one-hot winner (all zero when nothing is requested)
//   idx   : binary index of the winner
//   valid : at least one request is active
module rr_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = cnt_width(N_REQ - 1)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        // The pointer itself is visited last, so a lone requester that was
        // just served can still win again.
        for (int k = 1; k <= N_REQ; k++) begin
            if (!valid) begin
                cand = IDX_W'((int'(ptr) + k) % N_REQ);
                if (req[cand]) begin
                    valid     = 1'b1;
                    idx       = cand;
                    gnt[cand] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter
// Round-robin scheduler sharing one SPI master between N_REQ requesters.
// It grants one requester at a time, drives the master start/data handshake,
// routes the master chip-select to the owner and returns the received word
// with a done pulse, or an err pulse if the transaction times out.
//   clk, reset : system clock, asynchronous active-low reset
//   req        : per-requester request levels
//   tx_data    : flattened TX words, slot i at [i*DATA_W +: DATA_W]
//   grant      : one-hot owner, high for the whole transaction
//   done, err  : one-cycle completion / timeout pulses to the owner
//   rx_data    : last received word, valid while any done bit is high
//   spi        : link to the SPI master (start, tx_data, rx_data, busy,
//                done, cs)
//   cs_out     : per-slave chip-selects
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int   N_REQ      = 4,
    parameter int   DATA_W     = SPI_DATA_W,
    parameter int   GAP_CYCLES = 8,
    parameter int   TIMEOUT    = 1024,
    parameter logic CS_ACTIVE  = CS_ACTIVE_LVL
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] tx_data,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic [DATA_W-1:0]       rx_data,
    spi_arbiter_if.master           spi,
    output logic [N_REQ-1:0]        cs_out
);

    localparam int IDX_W   = cnt_width(N_REQ - 1);
    localparam int TIMER_W = cnt_width(TIMEOUT);
    localparam int GAP_W   = cnt_width(GAP_CYCLES);

    localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(TIMEOUT);
    localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // With no gap requested a finished transaction returns straight to IDLE.
    localparam arb_state_e POST_TXN_STATE = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    arb_state_e         state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   err_q, err_d;
    logic               spi_start_q, spi_start_d;
    logic [DATA_W-1:0]  spi_tx_data_q, spi_tx_data_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               spi_done_prev_q, spi_done_prev_d;

    logic [N_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [DATA_W-1:0]  tx_sel;
    logic               done_rise;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // TX word of the requester about to be granted.
    always_comb begin
        tx_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                tx_sel = tx_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // transfer_done is a multi-cycle level, so only its 0->1 edge counts.
    assign done_rise = spi.done & ~spi_done_prev_q;

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        done_d          = '0;
        err_d           = '0;
        spi_start_d     = spi_start_q;
        spi_tx_data_d   = spi_tx_data_q;
        rx_data_d       = rx_data_q;
        ptr_d           = ptr_q;
        timer_d         = timer_q;
        gap_cnt_d       = gap_cnt_q;
        spi_done_prev_d = spi.done;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d       = pick_gnt;
                    spi_start_d   = 1'b1;
                    spi_tx_data_d = tx_sel;
                    ptr_d         = pick_idx;
                    timer_d       = '0;
                    state_d       = ST_START;
                end
            end

            ST_START: begin
                if (timer_q == TIMEOUT_VAL) begin
                    spi_start_d = 1'b0;
                    err_d       = grant_q;
                    grant_d     = '0;
                    gap_cnt_d   = '0;
                    state_d     = POST_TXN_STATE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                    // Start is held until the master shows it has taken it.
                    if (spi.busy) begin
                        spi_start_d = 1'b0;
                        state_d     = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                // A completion edge beats a timeout landing on the same cycle.
                if (done_rise) begin
                    rx_data_d = spi.rx_data;
                    done_d    = grant_q;
                    grant_d   = '0;
                    gap_cnt_d = '0;
                    state_d   = POST_TXN_STATE;
                end else if (timer_q == TIMEOUT_VAL) begin
                    spi_start_d = 1'b0;
                    err_d       = grant_q;
                    grant_d     = '0;
                    gap_cnt_d   = '0;
                    state_d     = POST_TXN_STATE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset aborts any transaction outright; no done/err pulse is produced.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            grant_q         <= '0;
            done_q          <= '0;
            err_q           <= '0;
            spi_start_q     <= 1'b0;
            spi_tx_data_q   <= '0;
            rx_data_q       <= '0;
            ptr_q           <= IDX_W'(N_REQ - 1);
            timer_q         <= '0;
            gap_cnt_q       <= '0;
            spi_done_prev_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            done_q          <= done_d;
            err_q           <= err_d;
            spi_start_q     <= spi_start_d;
            spi_tx_data_q   <= spi_tx_data_d;
            rx_data_q       <= rx_data_d;
            ptr_q           <= ptr_d;
            timer_q         <= timer_d;
            gap_cnt_q       <= gap_cnt_d;
            spi_done_prev_q <= spi_done_prev_d;
        end
    end

    // Only the owner sees the master's chip-select; everyone else idles.
    always_comb begin
        cs_out = {N_REQ{~CS_ACTIVE}};
        for (int j = 0; j < N_REQ; j++) begin
            if (grant_q[j]) begin
                cs_out[j] = spi.cs;
            end
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rx_data     = rx_data_q;
    assign spi.start   = spi_start_q;
    assign spi.tx_data = spi_tx_data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter
// Self-checking bench for spi_arbiter: a behavioural SPI master on the slave
// modport, a done/rx_data scoreboard fed whenever requests are driven, and
// one task per scenario.
module tb_spi_arbiter;
    import spi_pkg::*;

    localparam int N_REQ       = 4;
    localparam int DATA_W      = 16;
    localparam int GAP_CYCLES  = 8;
    localparam int TIMEOUT     = 64;
    localparam int XFER_CYCLES = 20;
    localparam int DONE_LEN    = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] tx_data;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        done;
    logic [N_REQ-1:0]        err;
    logic [DATA_W-1:0]       rx_data;
    logic [N_REQ-1:0]        cs_out;

    spi_arbiter_if #(.DATA_W(DATA_W)) spi_if ();

    spi_arbiter #(
        .N_REQ      (N_REQ),
        .DATA_W     (DATA_W),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .CS_ACTIVE  (1'b0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .tx_data (tx_data),
        .grant   (grant),
        .done    (done),
        .err     (err),
        .rx_data (rx_data),
        .spi     (spi_if.master),
        .cs_out  (cs_out)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int   checks   = 0;
    int   failures = 0;
    logic model_en    = 1'b1;
    logic err_allowed = 1'b0;

    typedef struct {
        logic [N_REQ-1:0]  onehot;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    task automatic set_slot(input int i, input logic [DATA_W-1:0] v);
        tx_data[i*DATA_W +: DATA_W] = v;
    endtask

    // Behavioural SPI master: takes start, stays busy for a while, then
    // returns the transmitted word (loopback) with a multi-cycle done level.
    initial begin : spi_model
        logic [DATA_W-1:0] word;
        spi_if.busy    = 1'b0;
        spi_if.done    = 1'b0;
        spi_if.cs      = 1'b1;
        spi_if.rx_data = '0;
        forever begin
            @(negedge clk);
            if (model_en && spi_if.start && !spi_if.busy) begin
                word        = spi_if.tx_data;
                spi_if.busy = 1'b1;
                spi_if.cs   = 1'b0;
                repeat (XFER_CYCLES) @(negedge clk);
                spi_if.rx_data = word;
                spi_if.cs      = 1'b1;
                spi_if.busy    = 1'b0;
                spi_if.done    = 1'b1;
                repeat (DONE_LEN) @(negedge clk);
                spi_if.done = 1'b0;
            end
        end
    end

    // Scoreboard consumer: every done pulse must match the next expected
    // owner and received word.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            if (done !== '0) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done: got %b required none", done);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if (done !== e.onehot) begin
                        failures++;
                        $display("[TB] FAIL sb_done: got %b required %b", done, e.onehot);
                    end
                    checks++;
                    if (rx_data !== e.data) begin
                        failures++;
                        $display("[TB] FAIL sb_rx_data: got %h required %h", rx_data, e.data);
                    end
                end
            end
            if (err !== '0 && !err_allowed) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_err: got %b required 0000", err);
            end
            if ((done & err) !== '0) begin
                checks++;
                failures++;
                $display("[TB] FAIL done_err_overlap: done %b err %b", done, err);
            end
        end
    end

    task automatic test_reset;
        reset   = 1'b0;
        req     = '0;
        tx_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (grant !== 4'b0000) begin failures++; $display("[TB] FAIL reset_grant: got %b required 0000", grant); end
        checks++; if (done !== 4'b0000) begin failures++; $display("[TB] FAIL reset_done: got %b required 0000", done); end
        checks++; if (err !== 4'b0000) begin failures++; $display("[TB] FAIL reset_err: got %b required 0000", err); end
        checks++; if (spi_if.start !== 1'b0) begin failures++; $display("[TB] FAIL reset_start: got %b required 0", spi_if.start); end
        checks++; if (spi_if.tx_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_tx: got %h required 0000", spi_if.tx_data); end
        checks++; if (rx_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_rx: got %h required 0000", rx_data); end
        checks++; if (cs_out !== 4'b1111) begin failures++; $display("[TB] FAIL reset_cs: got %b required 1111", cs_out); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fairness;
        logic [DATA_W-1:0] words [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        int order [5] = '{0, 1, 2, 3, 0};
        int d_cyc;
        int g_cyc;
        int n;
        for (int i = 0; i < N_REQ; i++) set_slot(i, words[i]);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) sb_q.push_back('{onehot: 4'b0001 << order[k], data: words[order[k]]});
        d_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (grant === 4'b0000 && n < 300) begin @(negedge clk); n++; end
            g_cyc = cycle;
            checks++;
            if (grant !== (4'b0001 << order[k])) begin
                failures++;
                $display("[TB] FAIL fair_grant[%0d]: got %b required %b", k, grant, 4'b0001 << order[k]);
            end
            if (k > 0) begin
                checks++;
                if (g_cyc - d_cyc != GAP_CYCLES + 1) begin
                    failures++;
                    $display("[TB] FAIL fair_gap[%0d]: got %0d cycles required %0d", k, g_cyc - d_cyc, GAP_CYCLES + 1);
                end
            end
            n = 0;
            while (done === 4'b0000 && n < 300) begin @(negedge clk); n++; end
            d_cyc = cycle;
            checks++;
            if (grant !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL fair_grant_clear[%0d]: got %b required 0000", k, grant);
            end
            if (k < 4) @(negedge clk);
        end
    endtask

    // Entered while the previous transaction's gap is still running.
    task automatic test_withdraw;
        int n;
        @(negedge clk);
        set_slot(1, 16'h1E1E);
        set_slot(3, 16'h3C3C);
        req = 4'b1010;
        sb_q.push_back('{onehot: 4'b1000, data: 16'h3C3C});
        repeat (3) @(negedge clk);
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("[TB] FAIL withdraw_early: got %b required 0000", grant); end
        req = 4'b1000;
        n = 0;
        while (grant === 4'b0000 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (grant !== 4'b1000) begin failures++; $display("[TB] FAIL withdraw_grant: got %b required 1000", grant); end
        @(negedge clk);
        req = 4'b0000;
        n = 0;
        while (done === 4'b0000 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (done !== 4'b1000) begin failures++; $display("[TB] FAIL withdraw_done: got %b required 1000", done); end
    endtask

    task automatic test_single;
        int n;
        repeat (GAP_CYCLES + 2) @(negedge clk);
        set_slot(2, 16'hA5C3);
        req = 4'b0100;
        sb_q.push_back('{onehot: 4'b0100, data: 16'hA5C3});
        @(negedge clk);
        checks++; if (grant !== 4'b0100) begin failures++; $display("[TB] FAIL single_grant: got %b required 0100", grant); end
        checks++; if (spi_if.start !== 1'b1) begin failures++; $display("[TB] FAIL single_start: got %b required 1", spi_if.start); end
        checks++; if (spi_if.tx_data !== 16'hA5C3) begin failures++; $display("[TB] FAIL single_tx: got %h required a5c3", spi_if.tx_data); end
        @(negedge clk);
        checks++; if (spi_if.start !== 1'b0) begin failures++; $display("[TB] FAIL single_start_drop: got %b required 0", spi_if.start); end
        checks++; if (cs_out !== 4'b1011) begin failures++; $display("[TB] FAIL single_cs: got %b required 1011", cs_out); end
        n = 0;
        while (done === 4'b0000 && n < 300) begin @(negedge clk); n++; end
        checks++; if (done !== 4'b0100) begin failures++; $display("[TB] FAIL single_done: got %b required 0100", done); end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (done !== 4'b0000) begin failures++; $display("[TB] FAIL single_done_width: got %b required 0000", done); end
        checks++; if (rx_data !== 16'hA5C3) begin failures++; $display("[TB] FAIL single_rx_hold: got %h required a5c3", rx_data); end
    endtask

    task automatic test_timeout;
        int   n;
        int   elapsed;
        logic start_held;
        repeat (GAP_CYCLES + 2) @(negedge clk);
        model_en    = 1'b0;
        err_allowed = 1'b1;
        set_slot(0, 16'h0F0F);
        req = 4'b0001;
        n = 0;
        while (grant === 4'b0000 && n < 300) begin @(negedge clk); n++; end
        elapsed    = 0;
        start_held = 1'b1;
        while (err === 4'b0000 && elapsed < 200) begin
            start_held = start_held & spi_if.start;
            @(negedge clk);
            elapsed++;
        end
        checks++; if (elapsed != TIMEOUT + 1) begin failures++; $display("[TB] FAIL timeout_latency: got %0d required %0d", elapsed, TIMEOUT + 1); end
        checks++; if (err !== 4'b0001) begin failures++; $display("[TB] FAIL timeout_err: got %b required 0001", err); end
        checks++; if (start_held !== 1'b1) begin failures++; $display("[TB] FAIL timeout_start_held: got %b required 1", start_held); end
        checks++; if (spi_if.start !== 1'b0) begin failures++; $display("[TB] FAIL timeout_start_drop: got %b required 0", spi_if.start); end
        checks++; if (grant !== 4'b0000) begin failures++; $display("[TB] FAIL timeout_grant: got %b required 0000", grant); end
        checks++; if (rx_data !== 16'hA5C3) begin failures++; $display("[TB] FAIL timeout_rx: got %h required a5c3", rx_data); end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (err !== 4'b0000) begin failures++; $display("[TB] FAIL timeout_err_width: got %b required 0000", err); end
        err_allowed = 1'b0;
        model_en    = 1'b1;
    endtask

    task automatic test_reset_mid;
        int n;
        repeat (GAP_CYCLES + 2) @(negedge clk);
        set_slot(1, 16'h7777);
        req = 4'b0010;
        n = 0;
        while (spi_if.busy !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("[TB] FAIL rstmid_grant: got %b required 0000", grant); end
        checks++; if (spi_if.start !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_start: got %b required 0", spi_if.start); end
        checks++; if (spi_if.tx_data !== 16'h0000) begin failures++; $display("[TB] FAIL rstmid_tx: got %h required 0000", spi_if.tx_data); end
        checks++; if (rx_data !== 16'h0000) begin failures++; $display("[TB] FAIL rstmid_rx: got %h required 0000", rx_data); end
        checks++; if (cs_out !== 4'b1111) begin failures++; $display("[TB] FAIL rstmid_cs: got %b required 1111", cs_out); end
        set_slot(0, 16'h0123);
        req = 4'b0011;
        sb_q.push_back('{onehot: 4'b0001, data: 16'h0123});
        sb_q.push_back('{onehot: 4'b0010, data: 16'h7777});
        repeat (40) @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (grant === 4'b0000 && n < 300) begin @(negedge clk); n++; end
        checks++; if (grant !== 4'b0001) begin failures++; $display("[TB] FAIL rstmid_first: got %b required 0001", grant); end
        n = 0;
        while (done === 4'b0000 && n < 300) begin @(negedge clk); n++; end
        req = 4'b0010;
        n = 0;
        while (grant === 4'b0000 && n < 300) begin @(negedge clk); n++; end
        checks++; if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL rstmid_second: got %b required 0010", grant); end
        n = 0;
        while (done === 4'b0000 && n < 300) begin @(negedge clk); n++; end
        req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        req     = '0;
        tx_data = '0;
        test_reset();
        test_fairness();
        test_withdraw();
        test_single();
        test_timeout();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL sb_leftover: got %0d pending required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin scheduler that shares the single 16-bit SPI master between `N_REQ` on-chip requesters. It queues transfer requests, drives the master's start/data handshake, and routes the master's chip-select to the granted slave. It returns received data and a completion or error pulse to the owner. It sits between the control logic and the SPI master, in the system `clk` domain, while the master runs on its divided bit clock.

## Interface
- `N_REQ`, 4: number of requesters, and of slave chip-selects.
- `DATA_W`, 16: SPI word width; must equal the master's word width.
- `GAP_CYCLES`, 8: minimum idle `clk` cycles between transactions; must be ≥ the master's clock-divide ratio.
- `TIMEOUT`, 1024: maximum `clk` cycles from grant to completion before abort.
- `CS_ACTIVE`, 1'b0: active level of `cs_out`, matching the master.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `req`  in  N_REQ  per-requester request level.
- `tx_data`  in  N_REQ*DATA_W  flattened per-requester TX words; slot i occupies bits `[i*DATA_W +: DATA_W]`.
- `grant`  out  N_REQ  one-hot; high for the whole transaction of the owner.
- `done`  out  N_REQ  1-cycle pulse to the owner on successful completion.
- `err`  out  N_REQ  1-cycle pulse to the owner on timeout abort.
- `rx_data`  out  DATA_W  last received word; valid when any `done` bit is high.
- `spi_start`  out  1  to master `start_transfer`.
- `spi_tx_data`  out  DATA_W  to master `data_to_tx`.
- `spi_rx_data`  in  DATA_W  from master `data_rx`.
- `spi_busy`  in  1  from master `transfer_busy`.
- `spi_done`  in  1  from master `transfer_done`; a level that lasts one bit-clock period.
- `spi_cs`  in  1  from master `cs`.
- `cs_out`  out  N_REQ  per-slave chip-select.

## Operation
- **Reset values:** `grant`=0, `done`=0, `err`=0, `spi_start`=0, `spi_tx_data`=0, `rx_data`=0. Round-robin pointer = N_REQ-1, so requester 0 wins first.
- **Reset behaviour:** asserting `reset` mid-transaction aborts immediately. No `done` or `err` pulse is produced.
- **Requester rule:** hold `req` and the `tx_data` slot stable until `done` or `err`. Dropping `req` before grant withdraws the request. Dropping it after grant is ignored; the transaction completes.
- **IDLE:** if any `req` is high, grant the first requester at or after pointer+1, wrapping at N_REQ-1→0. On the next cycle:
  - `grant[i]`=1, `spi_start`=1, `spi_tx_data`=slot i;
  - pointer=i;
  - go to START.
- **START:** hold `spi_start` until `spi_busy` is sampled high, then drop it and go to WAIT.
- **WAIT:** wait for a rising edge of `spi_done`, detected as registered 0 followed by current 1. On that edge:
  - `rx_data`←`spi_rx_data`;
  - `done[i]` pulses for 1 cycle;
  - `grant` clears;
  - go to GAP.
- **Timeout:** a counter runs in START and WAIT. At `TIMEOUT` it:
  - drops `spi_start`;
  - pulses `err[i]`;
  - clears `grant`;
  - goes to GAP. `rx_data` is unchanged.
- **GAP:** count `GAP_CYCLES`, then return to IDLE. With `GAP_CYCLES`=0, go straight to IDLE.
- **Chip-select routing:** `cs_out[j]` = `spi_cs` when `grant[j]`, else `!CS_ACTIVE` (combinational).
- **Concurrent requests:** new requests arriving during a transaction wait. Simultaneous requests resolve strictly by round-robin order.

## Timing
- **Latency:** `req` rises in IDLE at cycle t → `grant` and `spi_start` high at t+1.
- **Completion:** `spi_done` rising edge at cycle d → `done` and `rx_data` valid at d+1.
- **Back-to-back:** the earliest next grant is d+1+GAP_CYCLES+1.
- **`spi_start` width:** at least until `spi_busy` is seen, so it spans one full bit-clock edge of the master.
- **`done`/`err` exclusivity:** `done` and `err` never pulse in the same cycle.
- **Simultaneous events:** if the timeout and the `spi_done` edge coincide, `done` wins.

## Structure
- Shared header `spi_pkg`:
  - state encoding IDLE / START / WAIT / GAP;
  - `SPI_DATA_W`=16;
  - CS active-level constant.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req` and pointer. It returns a one-hot grant and an index. The FSM, counters and edge detect stay in `spi_arbiter`.

## Test plan
- **Single request:** req[2]=1, tx 0xA5C3, loopback miso=mosi → `grant`=0100, `spi_tx_data`=0xA5C3, `done[2]` once, `rx_data`=0xA5C3, `cs_out`=1011 during transfer.
- **Fairness:** req=1111 held continuously → grant order 0,1,2,3,0. Every transaction is separated by ≥ GAP_CYCLES idle cycles.
- **Timeout:** `spi_busy` tied 0, TIMEOUT=64 → `err[0]` pulses 65 cycles after grant. `spi_start` drops and `rx_data` is unchanged.
- **Request withdrawal:** req[1] dropped before grant while req[3] is high → only requester 3 is served. Dropping req[3] after grant still yields `done[3]`.
- **Reset mid-transfer:** reset asserted in WAIT → all outputs return to reset values immediately. After release, req[1] and req[0] both high → requester 0 is served first.
